// File: rtl/sdram_init_refresh_ctrl.sv
// SDRAM power-up init sequencer and auto-refresh scheduler; requests the bus from
// the arbiter for each refresh and drives registered command/address outputs.
module sdram_init_refresh_ctrl #(
   parameter int unsigned INIT_WAIT_CYCLES = 20000,
   parameter int unsigned REFRESH_INTERVAL = 780,
   parameter int unsigned T_RP             = 2,
   parameter int unsigned T_RFC            = 7,
   parameter int unsigned T_MRD            = 2,
   parameter logic [11:0] MODE_REG         = 12'h020
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        ref_gnt_i,
   output logic        ref_req_o,
   output logic        ref_done_o,
   output logic        busy_o,
   output logic        init_done_o,
   output logic        ref_overrun_o,
   output logic        cke_o,
   output logic        cs_n_o,
   output logic [2:0]  cmd_o,
   output logic [12:0] a_o,
   output logic [1:0]  ba_o
);
   // state | meaning
   // RST_WAIT | stable-clock NOP wait;  INIT_* / REF_* | command issued this cycle
   // WAIT_*   | NOPs until the shared counter hits 0;  IDLE | waiting for pending refreshes
   // REQ      | ref_req high, waiting for grant;  DONE | ref_done pulse, bus released next
   localparam int unsigned CNT_W = $clog2(INIT_WAIT_CYCLES + T_RP + T_RFC + T_MRD + 1);
   localparam int unsigned IV_W  = $clog2(REFRESH_INTERVAL + 1);

   localparam logic [2:0]  CMD_NOP = 3'b111;
   localparam logic [2:0]  CMD_PRE = 3'b010;
   localparam logic [2:0]  CMD_AR  = 3'b001;
   localparam logic [2:0]  CMD_LMR = 3'b000;
   localparam logic [12:0] A_ALL   = 13'h0400;

   typedef enum logic [3:0] {
      S_RST_WAIT, S_INIT_PRE, S_WAIT_RP, S_INIT_AR1, S_WAIT_RFC1, S_INIT_AR2,
      S_WAIT_RFC2, S_INIT_LMR, S_WAIT_MRD, S_IDLE, S_REQ, S_REF_PRE, S_REF_AR,
      S_WAIT_RFC, S_DONE
   } state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [IV_W-1:0]   iv_q, iv_d;
   logic [3:0]        pend_q, pend_d;
   logic              overrun_q, overrun_d;
   logic              init_done_q, cke_q, cs_n_q, ref_req_q, ref_done_q, busy_q;
   logic [2:0]        cmd_q;
   logic [12:0]       a_q;
   logic [1:0]        ba_q;
   logic              tick, init_rise, done_now, cnt_zero;

   assign cnt_zero  = (cnt_q == '0);
   assign init_rise = (state_q == S_WAIT_MRD) && cnt_zero;
   assign tick      = init_done_q && (iv_q == '0);
   assign done_now  = (state_q == S_DONE);

   always_comb begin
      iv_d      = iv_q;
      pend_d    = pend_q;
      overrun_d = overrun_q;
      if (init_rise || tick) begin
         iv_d = IV_W'(REFRESH_INTERVAL - 1);
      end else if (init_done_q) begin
         iv_d = iv_q - 1'b1;
      end
      // a tick and a completed refresh in the same cycle cancel out
      if (tick && !done_now) begin
         if (pend_q == 4'd8) overrun_d = 1'b1;
         else                pend_d    = pend_q + 4'd1;
      end else if (done_now && !tick) begin
         pend_d = pend_q - 4'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_RST_WAIT;
         cnt_q       <= '0;
         iv_q        <= '0;
         pend_q      <= '0;
         overrun_q   <= 1'b0;
         init_done_q <= 1'b0;
         cke_q       <= 1'b0;
         cs_n_q      <= 1'b1;
         cmd_q       <= CMD_NOP;
         a_q         <= '0;
         ba_q        <= '0;
         ref_req_q   <= 1'b0;
         ref_done_q  <= 1'b0;
         busy_q      <= 1'b1;
      end else begin
         iv_q       <= iv_d;
         pend_q     <= pend_d;
         overrun_q  <= overrun_d;
         cke_q      <= 1'b1;
         cs_n_q     <= 1'b0;
         cmd_q      <= CMD_NOP;
         a_q        <= '0;
         ba_q       <= '0;
         ref_done_q <= 1'b0;
         unique case (state_q)
            S_RST_WAIT: begin
               // cke_q low marks the first cycle out of reset
               if (!cke_q) begin
                  cnt_q <= CNT_W'(INIT_WAIT_CYCLES - 1);
               end else if (cnt_zero) begin
                  state_q <= S_INIT_PRE;
                  cmd_q   <= CMD_PRE;
                  a_q     <= A_ALL;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_INIT_PRE, S_REF_PRE: begin
               state_q <= S_WAIT_RP;
               cnt_q   <= CNT_W'(T_RP - 2);
            end
            S_WAIT_RP: begin
               if (cnt_zero) begin
                  state_q <= init_done_q ? S_REF_AR : S_INIT_AR1;
                  cmd_q   <= CMD_AR;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_INIT_AR1: begin
               state_q <= S_WAIT_RFC1;
               cnt_q   <= CNT_W'(T_RFC - 2);
            end
            S_WAIT_RFC1: begin
               if (cnt_zero) begin
                  state_q <= S_INIT_AR2;
                  cmd_q   <= CMD_AR;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_INIT_AR2: begin
               state_q <= S_WAIT_RFC2;
               cnt_q   <= CNT_W'(T_RFC - 2);
            end
            S_WAIT_RFC2: begin
               if (cnt_zero) begin
                  state_q <= S_INIT_LMR;
                  cmd_q   <= CMD_LMR;
                  a_q     <= {1'b0, MODE_REG};
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_INIT_LMR: begin
               state_q <= S_WAIT_MRD;
               cnt_q   <= CNT_W'(T_MRD - 2);
            end
            S_WAIT_MRD: begin
               if (cnt_zero) begin
                  state_q     <= S_IDLE;
                  init_done_q <= 1'b1;
                  busy_q      <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_IDLE: begin
               if (pend_q != 4'd0) begin
                  state_q   <= S_REQ;
                  ref_req_q <= 1'b1;
               end
            end
            S_REQ: begin
               if (ref_gnt_i) begin
                  state_q   <= S_REF_PRE;
                  ref_req_q <= 1'b0;
                  busy_q    <= 1'b1;
                  cmd_q     <= CMD_PRE;
                  a_q       <= A_ALL;
               end
            end
            S_REF_AR: begin
               state_q <= S_WAIT_RFC;
               cnt_q   <= CNT_W'(T_RFC - 2);
            end
            S_WAIT_RFC: begin
               if (cnt_zero) begin
                  state_q    <= S_DONE;
                  ref_done_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= S_RST_WAIT;
         endcase
      end
   end

   assign ref_req_o     = ref_req_q;
   assign ref_done_o    = ref_done_q;
   assign busy_o        = busy_q;
   assign init_done_o   = init_done_q;
   assign ref_overrun_o = overrun_q;
   assign cke_o         = cke_q;
   assign cs_n_o        = cs_n_q;
   assign cmd_o         = cmd_q;
   assign a_o           = a_q;
   assign ba_o          = ba_q;
endmodule
